// File: rtl/user_pkg.sv
// Shared types and helpers for the ASCON user subsystem OBI managers.
// Write-DMA state enum plus first/last byte-enable helpers.
package user_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        aid;
    } mgr_obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mgr_obi_r_t;

    typedef struct packed {
        logic       gnt;
        logic       rvalid;
        mgr_obi_r_t r;
    } mgr_obi_rsp_t;

    typedef enum logic [1:0] {
        WDMA_IDLE,
        WDMA_XFER,
        WDMA_FLUSH,
        WDMA_DRAIN
    } wdma_state_e;

    function automatic logic [3:0] wdma_first_be(input logic [1:0] o);
        return 4'b1111 << o;
    endfunction

    // Low (o+len)%4 bytes; a multiple of four means the whole word.
    function automatic logic [3:0] wdma_last_be(input logic [1:0] o, input logic [1:0] len);
        logic [1:0] r;
        r = o + len;
        case (r)
            2'd1:    return 4'b0001;
            2'd2:    return 4'b0011;
            2'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ascon_wdma_realign.sv
// Residual register and byte-select mux shifting the stream onto the destination offset.
// Without ASCON_WDMA_UNALIGNED_EN the word passes straight through.
module ascon_wdma_realign (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  o,
    input  logic [31:0] word,
    input  logic        load,
    input  logic        flush,
    output logic [31:0] aligned
);

`ifdef ASCON_WDMA_UNALIGNED_EN
    logic [31:0] res_q;
    logic [63:0] cat;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_q <= '0;
        end else if (load) begin
            res_q <= word;
        end
    end

    // Write byte j takes cat byte 4+j-o: previous word below, current word above.
    assign cat = {(flush ? 32'd0 : word), res_q};

    always_comb begin
        aligned = cat[63:32];
        case (o)
            2'd1:    aligned = cat[55:24];
            2'd2:    aligned = cat[47:16];
            2'd3:    aligned = cat[39:8];
            default: aligned = cat[63:32];
        endcase
    end
`else
    logic unused_realign;
    assign unused_realign = ^{clk_i, rst_i, o, load, flush};
    assign aligned = word;
`endif

endmodule

// File: rtl/ascon_stream_write_dma.sv
// OBI manager write DMA: word stream in, byte-enabled word writes out.
// Unaligned address/length support is built only with ASCON_WDMA_UNALIGNED_EN.
module ascon_stream_write_dma
    import user_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         awvalid,
    output logic         awready,
    input  logic [31:0]  awaddr,
    input  logic [31:0]  awlen,
    input  logic         wvalid,
    output logic         wready,
    input  logic [31:0]  wdata,
    output mgr_obi_req_t mgr_req_o,
    input  mgr_obi_rsp_t mgr_rsp_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);

    localparam logic [2:0] MaxOut = 3'(MaxOutstanding);

    wdma_state_e state_q, state_d;
    logic [31:0] addr_q;
    logic [30:0] words_left_q, wr_left_q;
    logic        stage_vld_q;
    logic [31:0] stage_data_q;
    logic [3:0]  stage_be_q;
    logic [2:0]  out_q;
    logic        err_q;

    logic [1:0]  cmd_o;
    logic [31:0] cmd_len;
    logic [32:0] w_sum, n_sum;
    logic        accept, issue, fire, dec, stage_free, wfire, flush_load, stage_load;
    logic [31:0] aligned;
    logic [3:0]  be_n;
    logic        unused_rsp;

`ifdef ASCON_WDMA_UNALIGNED_EN
    logic [1:0] o_q, len_lo_q;
    logic       first_q;
    assign cmd_o   = awaddr[1:0];
    assign cmd_len = awlen;
`else
    logic unused_cmd;
    assign unused_cmd = ^{awaddr[1:0], awlen[1:0]};
    assign cmd_o   = 2'd0;
    assign cmd_len = {awlen[31:2], 2'b00};
`endif

    assign w_sum = {1'b0, cmd_len} + {31'd0, cmd_o} + 33'd3;
    assign n_sum = {1'b0, cmd_len} + 33'd3;

    assign unused_rsp = ^mgr_rsp_i.r.rdata;

    assign awready    = (state_q == WDMA_IDLE);
    assign busy_o     = (state_q != WDMA_IDLE);
    assign err_o      = err_q;
    assign accept     = awvalid && awready;
    assign issue      = stage_vld_q && (out_q != MaxOut);
    assign fire       = issue && mgr_rsp_i.gnt;
    assign dec        = mgr_rsp_i.rvalid && (out_q != 3'd0);
    assign stage_free = !stage_vld_q || fire;
    assign wready     = (state_q == WDMA_XFER) && (words_left_q != 31'd0) && stage_free;
    assign wfire      = wvalid && wready;
    assign stage_load = wfire || flush_load;

    assign mgr_req_o = '{req: issue, we: 1'b1, be: stage_be_q, addr: addr_q,
                         wdata: stage_data_q, aid: 1'b0};

    ascon_wdma_realign u_realign (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
`ifdef ASCON_WDMA_UNALIGNED_EN
        .o      (o_q),
`else
        .o      (2'd0),
`endif
        .word   (wdata),
        .load   (wfire),
        .flush  (flush_load),
        .aligned(aligned)
    );

    always_comb begin
        be_n = 4'b1111;
`ifdef ASCON_WDMA_UNALIGNED_EN
        if (first_q) be_n = be_n & wdma_first_be(o_q);
        if (wr_left_q == 31'd1) be_n = be_n & wdma_last_be(o_q, len_lo_q);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= WDMA_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        done_o     = 1'b0;
        flush_load = 1'b0;
        case (state_q)
            WDMA_IDLE: begin
                if (accept) state_d = (cmd_len == 32'd0) ? WDMA_DRAIN : WDMA_XFER;
            end
            WDMA_XFER: begin
                // All words taken and the last staged write leaving: the trailing write
                // (if any) is built from the residual alone.
                if (words_left_q == 31'd0 && stage_free) begin
`ifdef ASCON_WDMA_UNALIGNED_EN
                    if (wr_left_q != 31'd0) begin
                        state_d    = WDMA_FLUSH;
                        flush_load = 1'b1;
                    end else begin
                        state_d = WDMA_DRAIN;
                    end
`else
                    state_d = WDMA_DRAIN;
`endif
                end
            end
            WDMA_FLUSH: begin
                if (fire) state_d = WDMA_DRAIN;
            end
            WDMA_DRAIN: begin
                if (out_q == 3'd0) begin
                    state_d = WDMA_IDLE;
                    done_o  = 1'b1;
                end
            end
            default: state_d = WDMA_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q       <= '0;
            words_left_q <= '0;
            wr_left_q    <= '0;
            stage_vld_q  <= 1'b0;
            stage_data_q <= '0;
            stage_be_q   <= '0;
            out_q        <= '0;
            err_q        <= 1'b0;
`ifdef ASCON_WDMA_UNALIGNED_EN
            o_q          <= '0;
            len_lo_q     <= '0;
            first_q      <= 1'b0;
`endif
        end else begin
            if (accept) begin
                words_left_q <= n_sum[32:2];
                wr_left_q    <= w_sum[32:2];
`ifdef ASCON_WDMA_UNALIGNED_EN
                o_q          <= cmd_o;
                len_lo_q     <= cmd_len[1:0];
                first_q      <= 1'b1;
`endif
            end

            if (stage_load) begin
                stage_vld_q  <= 1'b1;
                stage_data_q <= aligned;
                stage_be_q   <= be_n;
                wr_left_q    <= wr_left_q - 31'd1;
`ifdef ASCON_WDMA_UNALIGNED_EN
                first_q      <= 1'b0;
`endif
                if (wfire) words_left_q <= words_left_q - 31'd1;
            end else if (fire) begin
                stage_vld_q <= 1'b0;
            end

            if (accept)    addr_q <= {awaddr[31:2], 2'b00};
            else if (fire) addr_q <= addr_q + 32'd4;

            case ({fire, dec})
                2'b10:   out_q <= out_q + 3'd1;
                2'b01:   out_q <= out_q - 3'd1;
                default: out_q <= out_q;
            endcase

            if (accept)                                   err_q <= 1'b0;
            else if (mgr_rsp_i.rvalid && mgr_rsp_i.r.err) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ascon_stream_write_dma.sv
// Directed bench for ascon_stream_write_dma with a delayed-response OBI slave model.
// Expectations follow ASCON_WDMA_UNALIGNED_EN when it is defined for the build.
module tb_ascon_stream_write_dma;
    import user_pkg::*;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         awvalid, awready, wvalid, wready;
    logic [31:0]  awaddr, awlen, wdata;
    mgr_obi_req_t mgr_req_o;
    mgr_obi_rsp_t rsp;
    logic         busy_o, done_o, err_o;
    logic         gnt, rvalid, rerr;

    always #5 clk = ~clk;

    assign rsp = {gnt, rvalid, 32'd0, rerr};

    ascon_stream_write_dma #(.MaxOutstanding(2)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .awvalid  (awvalid),
        .awready  (awready),
        .awaddr   (awaddr),
        .awlen    (awlen),
        .wvalid   (wvalid),
        .wready   (wready),
        .wdata    (wdata),
        .mgr_req_o(mgr_req_o),
        .mgr_rsp_i(rsp),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bm(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Slave model and write logger; samples just before each rising edge.
    logic [31:0]  wa[64], wd[64];
    logic [3:0]   wb[64];
    logic         wwe[64];
    int           wn, cyc, acc_cyc, done_cyc, done_cnt, rv_cnt, rv_at_done;
    int           cur_out, max_out, stall_seen, rdly, gnt_hold;
    logic [7:0]   rv_pipe, er_pipe;
    logic         fire_prev, err_inj, stall_prev, gnt_on, fire;
    mgr_obi_req_t held;
    logic [31:0]  sw[8];

    initial begin
        wn = 0; cyc = 0; acc_cyc = 0; done_cyc = 0; done_cnt = 0; rv_cnt = 0;
        rv_at_done = 0; cur_out = 0; max_out = 0; stall_seen = 0;
        rv_pipe = '0; er_pipe = '0; fire_prev = 0; stall_prev = 0;
        rvalid = 0; rerr = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_i) begin
                rv_pipe = '0; er_pipe = '0; fire_prev = 0; stall_prev = 0;
            end else begin
                rv_pipe = {rv_pipe[6:0], fire_prev};
                er_pipe = {er_pipe[6:0], fire_prev & err_inj};
            end
            rvalid = rv_pipe[rdly-1];
            rerr   = er_pipe[rdly-1];
            #2;
            if (rst_i) begin
                cur_out = 0;
            end else begin
                if (stall_prev) begin
                    stall_seen++;
                    check("hold_req",   32'(mgr_req_o.req), 32'd1);
                    check("hold_addr",  mgr_req_o.addr,  held.addr);
                    check("hold_wdata", mgr_req_o.wdata, held.wdata);
                    check("hold_be",    32'(mgr_req_o.be), 32'(held.be));
                end
                fire = mgr_req_o.req && gnt;
                if (fire) begin
                    if (wn < 64) begin
                        wa[wn] = mgr_req_o.addr; wd[wn] = mgr_req_o.wdata;
                        wb[wn] = mgr_req_o.be;   wwe[wn] = mgr_req_o.we && !mgr_req_o.aid;
                    end
                    wn++;
                    cur_out++;
                end
                if (rvalid) begin
                    rv_cnt++;
                    cur_out--;
                end
                if (cur_out > max_out) max_out = cur_out;
                if (awvalid && awready) acc_cyc = cyc;
                if (done_o) begin
                    done_cnt++;
                    done_cyc = cyc;
                    rv_at_done = rv_cnt;
                end
                stall_prev = mgr_req_o.req && !gnt;
                held = mgr_req_o;
                fire_prev = fire;
            end
        end
    end

    initial begin
        gnt = 0;
        forever begin
            @(negedge clk);
            if (gnt_hold > 0) begin
                gnt = 0;
                gnt_hold--;
            end else begin
                gnt = gnt_on;
            end
        end
    end

    task automatic clear_log();
        for (int i = 0; i < 64; i++) begin
            wa[i] = '0; wd[i] = '0; wb[i] = '0; wwe[i] = 0;
        end
        wn = 0; rv_cnt = 0; max_out = 0; stall_seen = 0;
    endtask

    task automatic cmd(input logic [31:0] a, input logic [31:0] l);
        int   t;
        logic took;
        t = 0; took = 0;
        while (!took && t < 50) begin
            @(negedge clk);
            awvalid = 1; awaddr = a; awlen = l;
            #1 took = awready;
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        awvalid = 0;
        check("cmd_accept", 32'(took), 32'd1);
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            int   t;
            logic took;
            t = 0; took = 0;
            while (!took && t < 100) begin
                @(negedge clk);
                wvalid = 1; wdata = sw[i];
                #1 took = wready;
                @(posedge clk);
                t++;
            end
            if (!took) check("feed_timeout", 32'd0, 32'd1);
        end
        @(negedge clk);
        wvalid = 0;
    endtask

    task automatic wait_done(input int d0);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 300) begin
            @(negedge clk);
            #3;
            t++;
        end
        check("done_seen", 32'(done_cnt != d0), 32'd1);
        repeat (2) @(negedge clk);
        #3 check("done_pulses", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic chk_wr(input int i, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b);
        check($sformatf("wr%0d_addr", i), wa[i], a);
        check($sformatf("wr%0d_data", i), wd[i] & bm(wb[i]), d);
        check($sformatf("wr%0d_be", i), 32'(wb[i]), 32'(b));
        check($sformatf("wr%0d_we", i), 32'(wwe[i]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    int d0;

    initial begin
        rst_i = 1; awvalid = 0; wvalid = 0; awaddr = '0; awlen = '0; wdata = '0;
        gnt_on = 1; gnt_hold = 0; rdly = 1; err_inj = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_wready",  32'(wready), 32'd0);
        check("rst_req",     32'(mgr_req_o.req), 32'd0);
        check("rst_busy",    32'(busy_o), 32'd0);
        check("rst_done",    32'(done_o), 32'd0);
        check("rst_err",     32'(err_o), 32'd0);
        @(negedge clk);
        rst_i = 0;

        // Aligned two-word transfer.
        clear_log(); d0 = done_cnt;
        cmd(32'h1000, 32'd8);
        #1 check("busy_xfer", 32'(busy_o), 32'd1);
        sw[0] = 32'h03020100; sw[1] = 32'h07060504;
        feed(2);
        wait_done(d0);
        check("t1_nwr", 32'(wn), 32'd2);
        chk_wr(0, 32'h1000, 32'h03020100, 4'hF);
        chk_wr(1, 32'h1004, 32'h07060504, 4'hF);
        check("t1_rv_at_done", 32'(rv_at_done), 32'd2);
        check("t1_busy_after", 32'(busy_o), 32'd0);

        // Offset-1 destination, one word.
        clear_log(); d0 = done_cnt;
        cmd(32'h1001, 32'd4);
        sw[0] = 32'h44332211;
        feed(1);
        wait_done(d0);
`ifdef ASCON_WDMA_UNALIGNED_EN
        check("t2_nwr", 32'(wn), 32'd2);
        chk_wr(0, 32'h1000, 32'h33221100, 4'hE);
        chk_wr(1, 32'h1004, 32'h00000044, 4'h1);
`else
        check("t2_nwr", 32'(wn), 32'd1);
        chk_wr(0, 32'h1000, 32'h44332211, 4'hF);
`endif

        // Single byte inside a word.
        clear_log(); d0 = done_cnt;
        cmd(32'h2002, 32'd1);
        sw[0] = 32'h000000AA;
`ifdef ASCON_WDMA_UNALIGNED_EN
        feed(1);
        wait_done(d0);
        check("t3_nwr", 32'(wn), 32'd1);
        chk_wr(0, 32'h2000, 32'h00AA0000, 4'h4);
`else
        wait_done(d0);
        check("t3_nwr", 32'(wn), 32'd0);
`endif

        // Grant backpressure with slow responses.
        clear_log(); d0 = done_cnt; rdly = 3;
        cmd(32'h3000, 32'd24);
        for (int i = 0; i < 6; i++) sw[i] = 32'hA5A50000 + 32'(i * 17);
        gnt_hold = 5;
        feed(6);
        wait_done(d0);
        check("t4_nwr", 32'(wn), 32'd6);
        for (int i = 0; i < 6; i++)
            chk_wr(i, 32'h3000 + 32'(4 * i), 32'hA5A50000 + 32'(i * 17), 4'hF);
        check("t4_max_out", 32'(max_out), 32'd2);
        check("t4_stalled", 32'(stall_seen != 0), 32'd1);
        rdly = 1;

        // Zero length.
        clear_log(); d0 = done_cnt;
        cmd(32'h4000, 32'd0);
        wait_done(d0);
        check("t5_nwr", 32'(wn), 32'd0);
        check("t5_done_lat", 32'(done_cyc - acc_cyc), 32'd1);

        // Error response is sticky until the next command.
        clear_log(); d0 = done_cnt; err_inj = 1;
        cmd(32'h4100, 32'd4);
        sw[0] = 32'h12345678;
        feed(1);
        wait_done(d0);
        err_inj = 0;
        check("t6_err_set", 32'(err_o), 32'd1);
        d0 = done_cnt;
        cmd(32'h4200, 32'd0);
        #1 check("t6_err_clr", 32'(err_o), 32'd0);
        wait_done(d0);

        // Reset in the middle of a transfer, then a fresh command.
        clear_log(); gnt_on = 0;
        cmd(32'h5000, 32'd16);
        sw[0] = 32'hDEADBEEF;
        feed(1);
        #1 check("t7_req_pending", 32'(mgr_req_o.req), 32'd1);
        rst_i = 1;
        @(posedge clk);
        #1;
        check("t7_rst_req", 32'(mgr_req_o.req), 32'd0);
        check("t7_rst_awready", 32'(awready), 32'd1);
        check("t7_rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        rst_i = 0; gnt_on = 1;
        clear_log(); d0 = done_cnt;
        cmd(32'h6000, 32'd8);
        sw[0] = 32'hCAFE0001; sw[1] = 32'hCAFE0002;
        feed(2);
        wait_done(d0);
        check("t7_nwr", 32'(wn), 32'd2);
        chk_wr(0, 32'h6000, 32'hCAFE0001, 4'hF);
        chk_wr(1, 32'h6004, 32'hCAFE0002, 4'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ascon_stream_write_dma.md
# ascon_stream_write_dma

OBI manager write-DMA engine for the ASCON user subsystem: the write-side counterpart of the ASCON read DMA. It accepts a command (byte address, byte length), consumes an aligned little-endian 32-bit word stream, and issues OBI word writes with byte enables to an arbitrary, possibly unaligned, destination. It sits inside the ASCON wrapper and drives one slave port of the user manager OBI mux (for example, the auth or bdo output channel).

## Interface
- `MaxOutstanding`, default 2: maximum granted OBI writes awaiting `rvalid` (1..7).
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `awvalid`  in  1  command valid.
- `awready`  out  1  command ready; high only in IDLE.
- `awaddr`  in  32  destination byte address.
- `awlen`  in  32  byte length.
- `wvalid`  in  1  stream word valid.
- `wready`  out  1  stream word accepted when `wvalid && wready`.
- `wdata`  in  32  stream word; byte 0 is the first byte.
- `mgr_req_o`  out  `mgr_obi_req_t`  OBI request: `we=1`, `aid=0`, word-aligned `addr`.
- `mgr_rsp_i`  in  `mgr_obi_rsp_t`  OBI response.
- `busy_o`  out  1  command in progress.
- `done_o`  out  1  one-cycle pulse when the command completes.
- `err_o`  out  1  sticky; set on any `rvalid && r.err`, cleared on command accept.

## Operation
- States: IDLE, XFER, FLUSH, DRAIN.
  - IDLE→XFER on `awvalid && awready`. Latches `addr=awaddr & ~3`, `o=awaddr[1:0]`, `len=awlen`.
  - Computes `W=ceil((o+len)/4)` OBI writes and `N=ceil(len/4)` input words. Widths are 33-bit internally; there is no wrap handling beyond the 32-bit address space.
- `len=0`: IDLE→DRAIN directly, no writes; `done_o` pulses on the next cycle.
- XFER: each accepted stream word forms one staged write.
  - Staged data = bytes of `{wdata, residual}` selected so write byte j = stream byte 4k+j−o.
  - Residual register keeps the upper `o` bytes of the word.
  - After N words: go to FLUSH if W>N, else DRAIN once the last write is granted.
- FLUSH: one extra write built from the residual only, with no input consumed; → DRAIN on its grant.
- Byte enables:
  - First write: `4'b1111 << o`.
  - Last write: low `(o+len)%4` bytes, or all four if 0.
  - A single-write transfer ANDs the first and last masks.
  - All other writes use `4'b1111`.
- A staged request holds `req`, `addr`, `wdata`, `be` stable until `gnt`. `addr` increments by 4 per grant.
- Outstanding counter: +1 on `req&&gnt`, −1 on `rvalid`, both in the same cycle → unchanged. `req` is masked while the count equals `MaxOutstanding`.
- DRAIN→IDLE when the outstanding count is 0; `done_o` pulses in that transition cycle.
- `busy_o` = state != IDLE.
- Reset: state IDLE, counters 0, `mgr_req_o.req=0`, `awready=1`, `wready=0`, `busy_o=0`, `done_o=0`, `err_o=0`.
- Reset mid-transfer aborts immediately, and in-flight responses are ignored. Reset is domain-wide, so no OBI recovery is needed.

## Timing
- `awready` is registered from state: a command is accepted at cycle 0, and `wready` may rise at cycle 1.
- `wready` = XFER && words remaining && (stage empty || `req&&gnt` this cycle). This has a combinational dependency on `gnt`.
- A staged request appears the cycle after its word is accepted.
- Sustained throughput is one write per cycle when `gnt=1`, `rvalid` returns one cycle after grant, and `MaxOutstanding`≥2.
- `wvalid` may drop at any time; the engine stalls with the stage empty and `req=0`.

## Configuration
- `ASCON_WDMA_UNALIGNED_EN` defined: full byte-granular behaviour as above.
- Undefined:
  - `awaddr[1:0]` and `awlen[1:0]` are treated as 0 and `o=0`.
  - No residual register, no FLUSH state, `be` always `4'b1111`, W=N.

## Structure
- In `user_pkg`:
  - State enum `wdma_state_e`.
  - Functions `wdma_first_be(o)` and `wdma_last_be(o,len)`.
- Sub-module `ascon_wdma_realign`: residual register plus byte-select mux, with inputs `o`, `word`, `load`, `flush`; output the aligned write word.

## Test plan
- Aligned: addr 0x1000, len 8, words 0x03020100 and 0x07060504, `gnt=1` → writes to 0x1000 and 0x1004 with those data, be 0xF and 0xF; `done_o` after 2 `rvalid`.
- Offset 1: addr 0x1001, len 4, word 0x44332211 → 0x1000 data 0x332211xx be 0xE, then FLUSH 0x1004 data 0xxxxxxx44 be 0x1; W=2, N=1.
- Short inside a word: addr 0x2002, len 1, word 0x000000AA → single write to 0x2000, be 0x4, byte2=0xAA.
- Backpressure: `gnt` low for 5 cycles with `MaxOutstanding`=2 and `rvalid` delayed 3 cycles → `req`/`addr`/`wdata`/`be` stable, never more than 2 outstanding, no stream word lost.
- `len=0` → no `req`, `done_o` one cycle after accept; `r.err=1` on a write → `err_o` set until the next command.
- Reset asserted mid-XFER → next cycle `req=0` and `awready=1`; a fresh command completes correctly.
